pipe_issue_unit: RTL and testbench

//   Front end for the 4-stage register/ALU/writeback/memory pipeline: accepts packed

---
 rtl/pipe_isa_pkg.sv | 63 ++++++
 rtl/issue_fifo.sv | 62 ++++++
 rtl/pipe_issue_unit.sv | 149 ++++++++++++++
 tb/tb_pipe_issue_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_isa_pkg.sv
// Shared instruction-word layout, ALU function codes and issue FSM encoding
// for the register/ALU/writeback/memory pipeline front end.
package pipe_isa_pkg;

  localparam int INSTR_W = 24;
  localparam int CNT_W   = 5;

  localparam int FUNC_HI = 23;
  localparam int FUNC_LO = 20;
  localparam int RD_HI   = 19;
  localparam int RD_LO   = 16;
  localparam int RS1_HI  = 15;
  localparam int RS1_LO  = 12;
  localparam int RS2_HI  = 11;
  localparam int RS2_LO  = 8;
  localparam int ADDR_HI = 7;
  localparam int ADDR_LO = 0;

  localparam logic [3:0] FUNC_ADD   = 4'd0;
  localparam logic [3:0] FUNC_SUB   = 4'd1;
  localparam logic [3:0] FUNC_AND   = 4'd2;
  localparam logic [3:0] FUNC_PASSA = 4'd3;
  localparam logic [3:0] FUNC_OR    = 4'd4;
  localparam logic [3:0] FUNC_XOR   = 4'd5;
  localparam logic [3:0] FUNC_NOTA  = 4'd6;
  localparam logic [3:0] FUNC_PASSB = 4'd7;
  localparam logic [3:0] FUNC_INC   = 4'd8;
  localparam logic [3:0] FUNC_DEC   = 4'd9;
  localparam logic [3:0] FUNC_SHR   = 4'd10;
  localparam logic [3:0] FUNC_SHL   = 4'd11;
  localparam logic [3:0] FUNC_NOP   = FUNC_PASSA;

  // Field order matches the packed input word {func, rd, rs1, rs2, addr}.
  typedef struct packed {
    logic [3:0] func;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [7:0] addr;
  } instr_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] rd;
  } hist_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_STALL = 2'd2
  } issue_state_e;

  function automatic instr_t make_nop(input logic [7:0] nop_addr);
    instr_t w;
    w.func = FUNC_NOP;
    w.rd   = 4'd0;
    w.rs1  = 4'd0;
    w.rs2  = 4'd0;
    w.addr = nop_addr;
    return w;
  endfunction

endpackage

// File: rtl/issue_fifo.sv
// Instruction buffer: DEPTH x W circular FIFO with wrapping pointers and a
// separately held occupancy count. Push and pop may coincide at any count.
module issue_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 24,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop & (count_q != '0);
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    do_push  = push & ((count_q != CNT_W'(DEPTH)) | do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/pipe_issue_unit.sv
// Pipeline issue front end: buffers instruction words, issues one per clock and
// inserts NOP bubbles on RAW hazards. Optional counters under ISSUE_PERF_EN.
module pipe_issue_unit
  import pipe_isa_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter int         HAZ_DEPTH  = 1,
  parameter logic [7:0] NOP_ADDR   = 8'hFF
) (
  input  logic               clk1,
  input  logic               rst_n,
  input  logic               run,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               in_ready,
  output logic [3:0]         rs1,
  output logic [3:0]         rs2,
  output logic [3:0]         rd,
  output logic [3:0]         func,
  output logic [7:0]         addr,
  output logic               issue_valid,
  output logic [CNT_W-1:0]   fifo_count,
`ifdef ISSUE_PERF_EN
  output logic [15:0]        perf_issued,
  output logic [15:0]        perf_stalls,
`endif
  output issue_state_e       state_dbg
);

  // Handshake: a word transfers on any clock edge where in_valid and in_ready are
  // both high; in_ready depends only on the registered count, never on in_valid.

  logic [INSTR_W-1:0] fifo_rdata;
  instr_t             head;
  logic               fifo_full, fifo_empty;
  logic               push, issue_now, hazard;

  issue_state_e         state_q, state_d;
  hist_t [HAZ_DEPTH-1:0] hist_q, hist_d;
  instr_t               out_q, out_d;
  logic                 issue_valid_q, issue_valid_d;

  assign in_ready = ~fifo_full;
  assign push     = in_valid & in_ready;
  assign head     = fifo_rdata;

  issue_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (INSTR_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk1),
    .rst_n (rst_n),
    .push  (push),
    .pop   (issue_now),
    .wdata (in_instr),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZ_DEPTH; i++) begin
      if (hist_q[i].valid && ((hist_q[i].rd == head.rs1) || (hist_q[i].rd == head.rs2)))
        hazard = 1'b1;
    end
  end

  // Every state shares one transition rule, always evaluated on the current head.
  always_comb begin
    state_d   = ST_IDLE;
    issue_now = 1'b0;
    case (state_q)
      ST_IDLE, ST_ISSUE, ST_STALL: begin
        if (run && !fifo_empty) begin
          if (hazard) begin
            state_d = ST_STALL;
          end else begin
            state_d   = ST_ISSUE;
            issue_now = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_d         = issue_now ? head : make_nop(NOP_ADDR);
    issue_valid_d = issue_now;
    hist_d        = hist_q;
    hist_d[0].valid = issue_now;
    hist_d[0].rd    = issue_now ? head.rd : 4'd0;
    for (int i = 1; i < HAZ_DEPTH; i++) hist_d[i] = hist_q[i-1];
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      hist_q        <= '0;
      out_q         <= make_nop(NOP_ADDR);
      issue_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hist_q        <= hist_d;
      out_q         <= out_d;
      issue_valid_q <= issue_valid_d;
    end
  end

  assign func        = out_q.func;
  assign rd          = out_q.rd;
  assign rs1         = out_q.rs1;
  assign rs2         = out_q.rs2;
  assign addr        = out_q.addr;
  assign issue_valid = issue_valid_q;
  assign state_dbg   = state_q;

`ifdef ISSUE_PERF_EN
  logic [15:0] perf_issued_q, perf_issued_d;
  logic [15:0] perf_stalls_q, perf_stalls_d;

  // Counters advance on the same edge the counted state becomes visible.
  always_comb begin
    perf_issued_d = perf_issued_q;
    perf_stalls_d = perf_stalls_q;
    if (issue_now && (perf_issued_q != 16'hFFFF))
      perf_issued_d = perf_issued_q + 16'd1;
    if ((state_d == ST_STALL) && (perf_stalls_q != 16'hFFFF))
      perf_stalls_d = perf_stalls_q + 16'd1;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_issued_q <= perf_issued_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_pipe_issue_unit.sv
// Bench for pipe_issue_unit: directed scenarios plus randomized traffic checked
// against a transaction-level model of the buffer, hazard window and NOP rules.
module tb_pipe_issue_unit;
  import pipe_isa_pkg::*;

  localparam int DEPTH = 4;
  localparam int HAZ   = 1;
  localparam logic [23:0] NOP_WORD = {4'd3, 4'd0, 4'd0, 4'd0, 8'hFF};

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        in_valid = 1'b0;
  logic [23:0] in_instr = '0;
  logic        in_ready;
  logic [3:0]  rs1, rs2, rd, func;
  logic [7:0]  addr;
  logic        issue_valid;
  logic [4:0]  fifo_count;
  issue_state_e state_dbg;
`ifdef ISSUE_PERF_EN
  logic [15:0] perf_issued, perf_stalls;
`endif

  pipe_issue_unit #(.FIFO_DEPTH(DEPTH), .HAZ_DEPTH(HAZ), .NOP_ADDR(8'hFF)) dut (
    .clk1        (clk1),
    .rst_n       (rst_n),
    .run         (run),
    .in_valid    (in_valid),
    .in_instr    (in_instr),
    .in_ready    (in_ready),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .func        (func),
    .addr        (addr),
    .issue_valid (issue_valid),
    .fifo_count  (fifo_count),
`ifdef ISSUE_PERF_EN
    .perf_issued (perf_issued),
    .perf_stalls (perf_stalls),
`endif
    .state_dbg   (state_dbg)
  );

  always #5 clk1 = ~clk1;

  // Reference model: buffered words, recent-destination window, observation log.
  logic [23:0] exp_q[$];
  bit          hist_v[HAZ];
  logic [3:0]  hist_rd[HAZ];
  bit          obs_v[$];
  int          m_issued, m_stalls;
  int          total, bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    for (int k = 0; k < HAZ; k++) begin
      hist_v[k]  = 1'b0;
      hist_rd[k] = 4'd0;
    end
    m_issued = 0;
    m_stalls = 0;
  endtask

  // One clock: predict from the pre-edge inputs, clock, then compare everything.
  task automatic step(output bit acc);
    logic [23:0]  h;
    logic [23:0]  exp_w;
    bit           iss, haz;
    issue_state_e exp_st;
    h      = '0;
    iss    = 1'b0;
    haz    = 1'b0;
    exp_st = ST_IDLE;
    acc    = in_valid && (exp_q.size() < DEPTH);
    if (run && exp_q.size() > 0) begin
      h = exp_q[0];
      for (int k = 0; k < HAZ; k++)
        if (hist_v[k] && (hist_rd[k] == h[15:12] || hist_rd[k] == h[11:8])) haz = 1'b1;
      if (haz) begin
        exp_st = ST_STALL;
        m_stalls++;
      end else begin
        exp_st = ST_ISSUE;
        iss    = 1'b1;
        m_issued++;
        void'(exp_q.pop_front());
      end
    end
    for (int k = HAZ - 1; k > 0; k--) begin
      hist_v[k]  = hist_v[k-1];
      hist_rd[k] = hist_rd[k-1];
    end
    hist_v[0]  = iss;
    hist_rd[0] = iss ? h[19:16] : 4'd0;
    if (acc) exp_q.push_back(in_instr);
    exp_w = iss ? h : NOP_WORD;
    @(posedge clk1);
    #1;
    obs_v.push_back(issue_valid);
    chk("issue_valid", {31'd0, issue_valid}, {31'd0, iss});
    chk("out_word", {8'd0, func, rd, rs1, rs2, addr}, {8'd0, exp_w});
    chk("fifo_count", {27'd0, fifo_count}, exp_q.size());
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() < DEPTH});
    chk("state", {30'd0, state_dbg}, {30'd0, exp_st});
`ifdef ISSUE_PERF_EN
    chk("perf_issued", {16'd0, perf_issued}, m_issued);
    chk("perf_stalls", {16'd0, perf_stalls}, m_stalls);
`endif
  endtask

  task automatic push_word(input logic [23:0] w);
    bit acc;
    int n;
    in_valid = 1'b1;
    in_instr = w;
    n = 0;
    do begin
      step(acc);
      n++;
    end while (!acc && n < 40);
    if (!acc) chk("push_timeout", {31'd0, acc}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step(acc);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_issue_valid", {31'd0, issue_valid}, 32'd0);
    chk("rst_out_word", {8'd0, func, rd, rs1, rs2, addr}, {8'd0, NOP_WORD});
    chk("rst_fifo_count", {27'd0, fifo_count}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
    model_clear();
    @(posedge clk1);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [23:0] rand_word();
    return {4'($urandom_range(0, 15)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
            4'($urandom_range(0, 7)), 8'($urandom_range(0, 255))};
  endfunction

  function automatic int first_one();
    for (int i = 0; i < obs_v.size(); i++) if (obs_v[i]) return i;
    return -1;
  endfunction

  initial begin
    bit acc;
    int f, ones;
    total = 0;
    bad   = 0;
    model_clear();
    #12;
    do_reset();

    // Independent pair issues on consecutive cycles.
    run = 1'b1;
    obs_v.delete();
    push_word({FUNC_ADD, 4'd3, 4'd1, 4'd2, 8'h10});
    push_word({FUNC_SUB, 4'd6, 4'd4, 4'd5, 8'h20});
    idle(3);
    f = first_one();
    ones = 0;
    foreach (obs_v[i]) ones += obs_v[i];
    chk("t2_issue_count", ones, 32'd2);
    chk("t2_back_to_back", (f >= 0 && f + 1 < obs_v.size()) ? obs_v[f+1] : 0, 32'd1);

    // RAW on r5: exactly one bubble between producer and consumer.
    do_reset();
    run = 1'b1;
    obs_v.delete();
    push_word({FUNC_ADD, 4'd5, 4'd1, 4'd2, 8'h30});
    push_word({FUNC_OR,  4'd7, 4'd5, 4'd1, 8'h31});
    idle(4);
    f = first_one();
    chk("t3_bubble", (f >= 0 && f + 2 < obs_v.size()) ? {obs_v[f+1], obs_v[f+2]} : 2'b11, 32'b01);
`ifdef ISSUE_PERF_EN
    chk("t6_perf_issued", {16'd0, perf_issued}, 32'd2);
    chk("t6_perf_stalls", {16'd0, perf_stalls}, 32'd1);
`endif

    // Fill while paused, then release and accept the held fifth word.
    run = 1'b0;
    for (int i = 0; i < 4; i++) push_word({FUNC_XOR, 4'(8 + i), 4'd1, 4'd2, 8'(8'h40 + i)});
    chk("t4_count_full", {27'd0, fifo_count}, 32'd4);
    chk("t4_not_ready", {31'd0, in_ready}, 32'd0);
    run = 1'b1;
    push_word({FUNC_AND, 4'd12, 4'd3, 4'd4, 8'h44});
    idle(6);

    // Ten words through a full buffer so both pointers wrap.
    run = 1'b0;
    for (int i = 0; i < 4; i++) push_word({FUNC_INC, 4'(i), 4'd9, 4'd10, 8'(8'h50 + i)});
    run = 1'b1;
    for (int i = 4; i < 14; i++) push_word({FUNC_SHL, 4'(i), 4'd15, 4'd14, 8'(8'h50 + i)});
    idle(8);

    // Randomized traffic with pauses and one mid-stream reset.
    for (int i = 0; i < 600; i++) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_instr = rand_word();
      end
      run = ($urandom_range(0, 7) != 0);
      step(acc);
      if (acc) in_valid = 1'b0;
      if (i == 300) do_reset();
    end
    in_valid = 1'b0;
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
